// File: rtl/mc_ctrl.sv
// -----------------------------------------------------------------------------
// mc_ctrl : multi-cycle control unit for the MIPS-subset CPU.
//
// A Moore state machine walks the datapath through one micro-step per clock.
// Outputs depend on the current state and the instruction register (Inst).
// IRWrite/PCWrite in IF also follow MIO_ready, because the fetch completes
// only when memory delivers the word.
//
// Ports
//   clk, rst_n      rising-edge clock, asynchronous active-low reset
//   Inst[31:0]      IR contents (opcode [31:26], funct [5:0]), stable from ID
//   zero            ALU zero flag (branch gating happens in the datapath
//                   through PCWriteCond/Branch)
//   MIO_ready       memory access completes this cycle
//   MemRead, MemWrite, IorD, IRWrite, RegWrite, PCWrite, PCWriteCond, Branch
//   RegDst[1:0]     00 rt, 01 rd, 10 r31
//   MemtoReg[1:0]   00 ALUOut, 01 MDR, 10 PC
//   ALUSrcA[1:0]    00 PC, 01 rs, 10 rt, 11 zero-extended imm
//   ALUSrcB[2:0]    000 rt, 001 4, 010 sext imm, 011 sext imm<<2,
//                   100 shamt, 101 zext imm, 110 16
//   PCSource[1:0]   00 ALU result, 01 ALUOut, 10 jump target, 11 rs
//   ALU_operation   4-bit ALU function code
//   state[ST_W-1:0] current state, for debug
// -----------------------------------------------------------------------------
module mc_ctrl #(
    parameter int ST_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [31:0]     Inst,
    input  logic            zero,
    input  logic            MIO_ready,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IorD,
    output logic            IRWrite,
    output logic            RegWrite,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic            Branch,
    output logic [1:0]      RegDst,
    output logic [1:0]      MemtoReg,
    output logic [1:0]      ALUSrcA,
    output logic [2:0]      ALUSrcB,
    output logic [1:0]      PCSource,
    output logic [3:0]      ALU_operation,
    output logic [ST_W-1:0] state
);

    typedef enum logic [4:0] {
        S_IF  = 5'd0,
        S_ID  = 5'd1,
        S_MA  = 5'd2,
        S_MRD = 5'd3,
        S_MWB = 5'd4,
        S_MWR = 5'd5,
        S_REX = 5'd6,
        S_RWB = 5'd7,
        S_IEX = 5'd8,
        S_IWB = 5'd9,
        S_BEQ = 5'd10,
        S_BNE = 5'd11,
        S_J   = 5'd12,
        S_JAL = 5'd13,
        S_JR  = 5'd14,
        S_SHX = 5'd15
    } state_t;

    // ALU function codes
    localparam logic [3:0] ALU_AND  = 4'd0;
    localparam logic [3:0] ALU_OR   = 4'd1;
    localparam logic [3:0] ALU_ADD  = 4'd2;
    localparam logic [3:0] ALU_SLL  = 4'd3;
    localparam logic [3:0] ALU_NOR  = 4'd4;
    localparam logic [3:0] ALU_SRL  = 4'd5;
    localparam logic [3:0] ALU_SUB  = 4'd6;
    localparam logic [3:0] ALU_SLT  = 4'd7;
    localparam logic [3:0] ALU_XOR  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_SRA  = 4'd10;

    // Opcodes
    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_JR   = 6'h08;
    localparam logic [5:0] F_ADD  = 6'h20;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUB  = 6'h22;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;
    localparam logic [5:0] F_SLTU = 6'h2B;

    state_t     cur_state;
    state_t     nxt_state;
    logic [5:0] opcode;
    logic [5:0] funct;

    assign opcode = Inst[31:26];
    assign funct  = Inst[5:0];

    // The zero flag and the register/immediate fields are consumed by the
    // datapath, not by this decoder.
    logic unused_inputs;
    assign unused_inputs = ^{zero, Inst[25:6]};

    assign state = ST_W'(cur_state);

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking (<=) so every flop samples
    // values from before the edge; blocking here would create order-dependent
    // simulation races.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cur_state <= S_IF;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    // NOTE: every variable driven here is given a default before the case,
    // so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        nxt_state = S_IF;
        case (cur_state)
            S_IF:  nxt_state = MIO_ready ? S_ID : S_IF;
            S_ID: begin
                case (opcode)
                    OP_RTYPE: begin
                        case (funct)
                            F_SLL, F_SRL, F_SRA:               nxt_state = S_SHX;
                            F_JR:                              nxt_state = S_JR;
                            F_ADD, F_ADDU, F_SUB, F_SUBU,
                            F_AND, F_OR, F_XOR, F_NOR,
                            F_SLT, F_SLTU:                     nxt_state = S_REX;
                            default:                           nxt_state = S_IF;
                        endcase
                    end
                    OP_LW, OP_SW:                              nxt_state = S_MA;
                    OP_BEQ:                                    nxt_state = S_BEQ;
                    OP_BNE:                                    nxt_state = S_BNE;
                    OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
                    OP_ANDI, OP_ORI, OP_XORI, OP_LUI:          nxt_state = S_IEX;
                    OP_J:                                      nxt_state = S_J;
                    OP_JAL:                                    nxt_state = S_JAL;
                    // Unknown encodings fall back to fetch: a NOP.
                    default:                                   nxt_state = S_IF;
                endcase
            end
            S_MA:  nxt_state = (opcode == OP_LW) ? S_MRD : S_MWR;
            S_MRD: nxt_state = MIO_ready ? S_MWB : S_MRD;
            S_MWR: nxt_state = MIO_ready ? S_IF  : S_MWR;
            S_REX: nxt_state = S_RWB;
            S_SHX: nxt_state = S_RWB;
            S_IEX: nxt_state = S_IWB;
            default: nxt_state = S_IF;  // MWB, RWB, IWB, BEQ, BNE, J, JAL, JR
        endcase
    end

    // -------------------------------------------------------------------------
    // Output decode
    // -------------------------------------------------------------------------
    always_comb begin
        MemRead       = 1'b0;
        MemWrite      = 1'b0;
        IorD          = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        PCWrite       = 1'b0;
        PCWriteCond   = 1'b0;
        Branch        = 1'b0;
        RegDst        = 2'b00;
        MemtoReg      = 2'b00;
        ALUSrcA       = 2'b00;
        ALUSrcB       = 3'b000;
        PCSource      = 2'b00;
        ALU_operation = ALU_ADD;

        case (cur_state)
            S_IF: begin
                MemRead = 1'b1;
                ALUSrcB = 3'b001;
                // PC+4 and the IR are captured only when the fetch completes.
                IRWrite = MIO_ready;
                PCWrite = MIO_ready;
            end
            S_ID: begin
                // Speculative branch target into ALUOut.
                ALUSrcB = 3'b011;
            end
            S_MA: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 3'b010;
            end
            S_MRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
            end
            S_MWB: begin
                MemtoReg = 2'b01;
                RegWrite = 1'b1;
            end
            S_MWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
            end
            S_REX: begin
                ALUSrcA = 2'b01;
                case (funct)
                    F_SUB, F_SUBU: ALU_operation = ALU_SUB;
                    F_AND:         ALU_operation = ALU_AND;
                    F_OR:          ALU_operation = ALU_OR;
                    F_XOR:         ALU_operation = ALU_XOR;
                    F_NOR:         ALU_operation = ALU_NOR;
                    F_SLT:         ALU_operation = ALU_SLT;
                    F_SLTU:        ALU_operation = ALU_SLTU;
                    default:       ALU_operation = ALU_ADD;
                endcase
            end
            S_SHX: begin
                // Shifts operate on rt by shamt.
                ALUSrcA = 2'b10;
                ALUSrcB = 3'b100;
                case (funct)
                    F_SRL:   ALU_operation = ALU_SRL;
                    F_SRA:   ALU_operation = ALU_SRA;
                    default: ALU_operation = ALU_SLL;
                endcase
            end
            S_RWB: begin
                RegDst   = 2'b01;
                RegWrite = 1'b1;
            end
            S_IEX: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 3'b010;
                case (opcode)
                    OP_SLTI:  ALU_operation = ALU_SLT;
                    OP_SLTIU: ALU_operation = ALU_SLTU;
                    OP_ANDI: begin
                        ALUSrcB       = 3'b101;
                        ALU_operation = ALU_AND;
                    end
                    OP_ORI: begin
                        ALUSrcB       = 3'b101;
                        ALU_operation = ALU_OR;
                    end
                    OP_XORI: begin
                        ALUSrcB       = 3'b101;
                        ALU_operation = ALU_XOR;
                    end
                    OP_LUI: begin
                        // lui = zero-extended imm shifted left by 16.
                        ALUSrcA       = 2'b11;
                        ALUSrcB       = 3'b110;
                        ALU_operation = ALU_SLL;
                    end
                    default:  ALU_operation = ALU_ADD;
                endcase
            end
            S_IWB: begin
                RegWrite = 1'b1;
            end
            S_BEQ, S_BNE: begin
                ALUSrcA       = 2'b01;
                ALU_operation = ALU_SUB;
                PCWriteCond   = 1'b1;
                PCSource      = 2'b01;
                Branch        = (cur_state == S_BEQ);
            end
            S_J: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
            end
            S_JAL: begin
                PCSource = 2'b10;
                PCWrite  = 1'b1;
                RegDst   = 2'b10;
                MemtoReg = 2'b10;
                RegWrite = 1'b1;
            end
            S_JR: begin
                PCSource = 2'b11;
                PCWrite  = 1'b1;
            end
            default: begin
            end
        endcase

        // While reset is held the state already reads IF; suppress every
        // write enable so nothing in the datapath changes until release.
        if (!rst_n) begin
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            IRWrite     = 1'b0;
            RegWrite    = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
        end
    end

endmodule
